// File: rtl/operand_mux_arbiter_pkg.sv
// Shared types for the two-requester operand mux arbiter: FSM state encoding
// and the source encodings reported on out_src / sel.
package operand_mux_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   // Lock state that belongs to a given source.
   function automatic state_t lock_of(input logic src);
      return (src == SRC_B) ? LOCK_B : LOCK_A;
   endfunction

endpackage

// File: rtl/operand_mux_arbiter_mux2_word.sv
// WIDTH-bit 2:1 select datapath; pure wiring, no arithmetic on the data.
module mux2_word #(
   parameter int WIDTH = 8
) (
   input  logic             i_sel,
   input  logic [WIDTH-1:0] i_d0,
   input  logic [WIDTH-1:0] i_d1,
   output logic [WIDTH-1:0] o_y
);

   assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/operand_mux_arbiter.sv
// Packet-aware round-robin arbiter between two requesters feeding one
// registered output beat; a packet, once started, holds the grant until last.
module operand_mux_arbiter
   import operand_mux_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_last,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_src,
   input  logic             out_ready,
   output logic             sel,
   output state_t           dbg_state
);

   // Handshakes: a beat moves on x_valid && x_ready in the same cycle; valid
   // is never expected to wait for ready, and ready never depends on a stall
   // of anything but the output register (load_en).

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_rr_last;
   logic             w_rr_last_nxt;
   logic             r_sel;
   logic             r_out_valid;
   logic             r_out_last;
   logic             r_out_src;
   logic [WIDTH-1:0] r_out_data;

   logic             w_load_en;
   logic             w_gnt_vld;
   logic             w_gnt_src;
   logic             w_sel;
   logic             w_accept;
   logic             w_acc_last;
   logic [WIDTH-1:0] w_mux_data;

   assign w_load_en = !r_out_valid || out_ready;

   // Grant decision: who would be served this cycle if the output can load.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_src = r_sel;
      case (r_state)
         IDLE: begin
            if (a_valid && b_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt_src = ~r_rr_last;
            end else if (a_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt_src = SRC_A;
            end else if (b_valid) begin
               w_gnt_vld = 1'b1;
               w_gnt_src = SRC_B;
            end
         end
         LOCK_A: begin
            w_gnt_vld = a_valid;
            w_gnt_src = SRC_A;
         end
         LOCK_B: begin
            w_gnt_vld = b_valid;
            w_gnt_src = SRC_B;
         end
         default: begin
            w_gnt_vld = 1'b0;
            w_gnt_src = r_sel;
         end
      endcase
   end

   // Output decode; reset gating keeps sel and readies low while rst_n = 0.
   always_comb begin
      w_sel      = rst_n && (w_gnt_vld ? w_gnt_src : r_sel);
      w_accept   = rst_n && w_load_en && w_gnt_vld;
      a_ready    = w_accept && (w_gnt_src == SRC_A);
      b_ready    = w_accept && (w_gnt_src == SRC_B);
      w_acc_last = (w_gnt_src == SRC_B) ? b_last : a_last;
   end

   // Next-state and round-robin pointer update.
   always_comb begin
      w_state_nxt   = r_state;
      w_rr_last_nxt = r_rr_last;
      if (w_accept) begin
         if (w_acc_last) begin
            w_state_nxt   = IDLE;
            w_rr_last_nxt = w_gnt_src;
         end else begin
            w_state_nxt = lock_of(w_gnt_src);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rr_last <= 1'b1;
         r_sel     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rr_last <= w_rr_last_nxt;
         r_sel     <= w_sel;
      end
   end

   mux2_word #(
      .WIDTH (WIDTH)
   ) u_mux2_word (
      .i_sel (w_sel),
      .i_d0  (a_data),
      .i_d1  (b_data),
      .o_y   (w_mux_data)
   );

   // Output register: a drain and a fresh load in one cycle simply overwrite.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_src   <= 1'b0;
         r_out_data  <= '0;
      end else if (w_load_en) begin
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_out_last <= w_acc_last;
            r_out_src  <= w_gnt_src;
            r_out_data <= w_mux_data;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_src   = r_out_src;
   assign sel       = w_sel;
   assign dbg_state = r_state;

endmodule
